// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : PC strobes, imem req/ack, decode valid/ready and redirect bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int n     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic [n-1:0]     pc_value;
    logic             IPC;
    logic             LPC;
    logic [n-1:0]     pc_target;
    logic             imem_req;
    logic [n-1:0]     imem_addr;
    logic             imem_ack;
    logic [W-1:0]     imem_data;
    logic [W-1:0]     instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             branch_req;
    logic [n-1:0]     branch_addr;
    logic             halt;
    logic [CNT_W-1:0] wait_cycles;

    modport master (
        input  pc_value, imem_ack, imem_data, instr_ready,
               branch_req, branch_addr, halt,
        output IPC, LPC, pc_target, imem_req, imem_addr,
               instr, instr_valid, wait_cycles
    );

    modport slave (
        output pc_value, imem_ack, imem_data, instr_ready,
               branch_req, branch_addr, halt,
        input  IPC, LPC, pc_target, imem_req, imem_addr,
               instr, instr_valid, wait_cycles
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Fetch control for the 3-stage pipe; drives PC strobes and imem.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int n     = 4,
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  wire                 clk,
    input  wire                 clear,
    fetch_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_WAIT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [W-1:0]     instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] wait_q,  wait_d;

    logic             w_ipc, w_lpc, w_req;
    logic [n-1:0]     w_target, w_addr;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        wait_d   = wait_q;
        w_ipc    = 1'b0;
        w_lpc    = 1'b0;
        w_req    = 1'b0;
        w_target = '0;
        w_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (!bus.halt) begin
                    state_d = S_REQ;
                    wait_d  = '0;
                end
            end
            S_REQ: begin
                w_req  = 1'b1;
                w_addr = bus.pc_value;
                // A redirect wins over a same-cycle ack; the read is simply refetched.
                if (bus.branch_req) begin
                    w_lpc    = 1'b1;
                    w_target = bus.branch_addr;
                    wait_d   = '0;
                end else if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    valid_d = 1'b1;
                    w_ipc   = 1'b1;
                    state_d = S_VALID;
                end else if (wait_q != {CNT_W{1'b1}}) begin
                    wait_d = wait_q + c_WAIT_ONE;
                end
            end
            S_VALID: begin
                if (bus.branch_req) begin
                    valid_d  = 1'b0;
                    w_lpc    = 1'b1;
                    w_target = bus.branch_addr;
                    wait_d   = '0;
                    state_d  = bus.halt ? S_IDLE : S_REQ;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    if (bus.halt) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REQ;
                        wait_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.IPC         = w_ipc;
    assign bus.LPC         = w_lpc;
    assign bus.pc_target   = w_target;
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.wait_cycles = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed vector table plus multi-cycle sequences for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clk;
    logic clear;
    logic [3:0] pc_q;
    int n_chk;
    int n_fail;

    fetch_sequencer_if #(.n(4), .W(8), .CNT_W(8)) bus ();

    fetch_sequencer #(.n(4), .W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference program counter: increments on IPC, loads on LPC, holds on both.
    always @(posedge clk) begin
        if (!clear)                    pc_q <= 4'd0;
        else if (bus.IPC && !bus.LPC)  pc_q <= pc_q + 4'd1;
        else if (bus.LPC && !bus.IPC)  pc_q <= bus.pc_target;
    end
    assign bus.pc_value = pc_q;

    typedef struct {
        logic       clr;
        logic       ack;
        logic [7:0] data;
        logic       rdy;
        logic       br;
        logic [3:0] baddr;
        logic       halt;
        logic       ipc;
        logic       lpc;
        logic [3:0] tgt;
        logic       req;
        logic [3:0] addr;
        logic [7:0] instr;
        logic       valid;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [7:0] data, input logic rdy,
                         input logic br, input logic [3:0] baddr, input logic halt);
        bus.imem_ack    = ack;
        bus.imem_data   = data;
        bus.instr_ready = rdy;
        bus.branch_req  = br;
        bus.branch_addr = baddr;
        bus.halt        = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the block in S_REQ with the PC at 0 and wait_cycles cleared.
    task automatic do_reset();
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        tick();
        clear = 1'b1;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //          clr  ack  data   rdy  br   badr halt | ipc lpc tgt  req addr instr  vld wc
        vecs[0]  = '{1'b0,1'b1,8'hFF,1'b1,1'b1,4'hF,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h00,1'b0,8'd0};
        vecs[1]  = '{1'b0,1'b1,8'hFF,1'b1,1'b1,4'hF,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h00,1'b0,8'd0};
        vecs[2]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h00,1'b0,8'd0};
        vecs[3]  = '{1'b1,1'b1,8'hA5,1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'h0,1'b1,4'h0,8'h00,1'b0,8'd0};
        vecs[4]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0,4'h0,8'hA5,1'b1,8'd0};
        vecs[5]  = '{1'b1,1'b1,8'h3C,1'b1,1'b0,4'h0,1'b0, 1'b1,1'b0,4'h0,1'b1,4'h1,8'hA5,1'b0,8'd0};
        vecs[6]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h3C,1'b1,8'd0};
        vecs[7]  = '{1'b1,1'b1,8'h77,1'b0,1'b1,4'hC,1'b0, 1'b0,1'b1,4'hC,1'b1,4'h2,8'h3C,1'b0,8'd0};
        vecs[8]  = '{1'b1,1'b1,8'h5A,1'b0,1'b0,4'h0,1'b0, 1'b1,1'b0,4'h0,1'b1,4'hC,8'h3C,1'b0,8'd0};
        vecs[9]  = '{1'b1,1'b0,8'h00,1'b1,1'b1,4'h3,1'b0, 1'b0,1'b1,4'h3,1'b0,4'h0,8'h5A,1'b1,8'd0};
        vecs[10] = '{1'b1,1'b1,8'h11,1'b0,1'b0,4'h0,1'b0, 1'b1,1'b0,4'h0,1'b1,4'h3,8'h5A,1'b0,8'd0};
        vecs[11] = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'h0,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h11,1'b1,8'd0};
        vecs[12] = '{1'b1,1'b0,8'h00,1'b1,1'b0,4'h0,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h11,1'b1,8'd0};
        vecs[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'h0,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h11,1'b0,8'd0};
        vecs[14] = '{1'b1,1'b1,8'hEE,1'b0,1'b0,4'h0,1'b1, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h11,1'b0,8'd0};
        vecs[15] = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b0,4'h0,8'h11,1'b0,8'd0};
        vecs[16] = '{1'b1,1'b0,8'h00,1'b0,1'b0,4'h0,1'b0, 1'b0,1'b0,4'h0,1'b1,4'h4,8'h11,1'b0,8'd0};

        clear = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 1'b1, 4'hF, 1'b1);
        tick();

        for (int i = 0; i < 17; i++) begin
            clear = vecs[i].clr;
            drive(vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].br, vecs[i].baddr, vecs[i].halt);
            #1;
            chk($sformatf("v%0d_ipc", i),   {31'd0, bus.IPC},          {31'd0, vecs[i].ipc});
            chk($sformatf("v%0d_lpc", i),   {31'd0, bus.LPC},          {31'd0, vecs[i].lpc});
            chk($sformatf("v%0d_excl", i),  {31'd0, bus.IPC & bus.LPC}, 32'd0);
            chk($sformatf("v%0d_tgt", i),   {28'd0, bus.pc_target},    {28'd0, vecs[i].tgt});
            chk($sformatf("v%0d_req", i),   {31'd0, bus.imem_req},     {31'd0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  {28'd0, bus.imem_addr},    {28'd0, vecs[i].addr});
            chk($sformatf("v%0d_instr", i), {24'd0, bus.instr},        {24'd0, vecs[i].instr});
            chk($sformatf("v%0d_valid", i), {31'd0, bus.instr_valid},  {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_wc", i),    {24'd0, bus.wait_cycles},  {24'd0, vecs[i].wc});
            tick();
        end

        // Three wait states: req held four cycles, IPC only with the ack.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 8'hC3, 1'b0, 1'b0, 4'h0, 1'b0);
            #1;
            chk($sformatf("w3_req%0d", i), {31'd0, bus.imem_req}, 32'd1);
            chk($sformatf("w3_ipc%0d", i), {31'd0, bus.IPC},      {31'd0, i == 3});
            chk($sformatf("w3_wc%0d", i),  {24'd0, bus.wait_cycles}, i);
            tick();
        end
        chk("w3_instr", {24'd0, bus.instr},       32'hC3);
        chk("w3_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("w3_pc",    {28'd0, pc_q},            32'd1);

        // 300 wait states: counter saturates at all-ones.
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        chk("sat_wc", {24'd0, bus.wait_cycles}, 32'd255);
        drive(1'b1, 8'h96, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("sat_ipc", {31'd0, bus.IPC},         32'd1);
        chk("sat_wc2", {24'd0, bus.wait_cycles}, 32'd255);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);

        // Decode stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("st_instr%0d", i), {24'd0, bus.instr},       32'h96);
            chk($sformatf("st_valid%0d", i), {31'd0, bus.instr_valid}, 32'd1);
            chk($sformatf("st_req%0d", i),   {31'd0, bus.imem_req},    32'd0);
            chk($sformatf("st_ipc%0d", i),   {31'd0, bus.IPC},         32'd0);
            chk($sformatf("st_pc%0d", i),    {28'd0, pc_q},            32'd1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("st_after_req",  {31'd0, bus.imem_req},    32'd1);
        chk("st_after_addr", {28'd0, bus.imem_addr},   32'd1);
        chk("st_after_wc",   {24'd0, bus.wait_cycles}, 32'd0);

        // Reset in the middle of a fetch; a late ack must be ignored.
        do_reset();
        #1;
        chk("mr_req", {31'd0, bus.imem_req}, 32'd1);
        clear = 1'b0;
        tick();
        clear = 1'b1;
        drive(1'b1, 8'h99, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("mr_req_drop", {31'd0, bus.imem_req}, 32'd0);
        chk("mr_ipc",      {31'd0, bus.IPC},      32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("mr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mr_instr", {24'd0, bus.instr},       32'd0);
        chk("mr_pc",    {28'd0, pc_q},            32'd0);
        chk("mr_req2",  {31'd0, bus.imem_req},    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
